// File: rtl/booth_pkg.sv
// Shared encodings for the Booth multiplier control interface.
// Imported by both the controller and the datapath so the op codes cannot drift apart.
package booth_pkg;

    typedef enum logic [1:0] {
        A_HOLD     = 2'b00,
        A_CLEAR    = 2'b01,
        A_LOAD_SUM = 2'b10,
        A_ASHR     = 2'b11
    } a_op_e;

    typedef enum logic [1:0] {
        Q_HOLD  = 2'b00,
        Q_LOAD  = 2'b01,
        Q_SHR   = 2'b10,
        Q_CLEAR = 2'b11
    } q_op_e;

    localparam logic ADDSUB_ADD = 1'b0;
    localparam logic ADDSUB_SUB = 1'b1;

endpackage

// File: rtl/booth_addsub.sv
// Combinational (WIDTH+1)-bit add/subtract of the Booth accumulator and multiplicand.
// Subtraction reuses the single adder via two's-complement inversion plus carry-in.
module booth_addsub
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] m,
    input  logic           sub,
    output logic [WIDTH:0] result
);

    logic [WIDTH:0] m_eff;
    logic [WIDTH:0] carry_in;

    always_comb begin
        m_eff    = m ^ {(WIDTH + 1){sub == ADDSUB_SUB}};
        carry_in = {{WIDTH{1'b0}}, sub == ADDSUB_SUB};
        result   = a + m_eff + carry_in;
    end

endmodule

// File: rtl/booth_datapath.sv
// Booth multiplier datapath: M/A/Q registers, Q-1 bit, add/subtract and coupled shift.
// Optional registered product output is enabled with `define BOOTH_PRODUCT_REG_EN.
module booth_datapath
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 mSignal,
    input  logic                 addSubSignal,
    input  logic [1:0]           aSignal,
    input  logic [1:0]           qSignal,
    input  logic                 finished,
    output logic [WIDTH-1:0]     qReg,
    output logic                 qNeg,
    output logic [WIDTH-1:0]     aReg,
    output logic [2*WIDTH-1:0]   product,
    output logic                 productValid
);

    // A and M carry one extra bit so that M = -2^(WIDTH-1) negates exactly.
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_neg;
    logic [WIDTH:0]   sum;
    a_op_e            a_op;
    q_op_e            q_op;

    assign a_op = a_op_e'(aSignal);
    assign q_op = q_op_e'(qSignal);

    booth_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a      (a_reg),
        .m      (m_reg),
        .sub    (addSubSignal),
        .result (sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg <= '0;
        end else if (mSignal) begin
            m_reg <= {multiplicand[WIDTH-1], multiplicand};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
        end else begin
            case (a_op)
                A_HOLD:     a_reg <= a_reg;
                A_CLEAR:    a_reg <= '0;
                A_LOAD_SUM: a_reg <= sum;
                A_ASHR:     a_reg <= {a_reg[WIDTH], a_reg[WIDTH:1]};
            endcase
        end
    end

    // SHR always takes the pre-edge A[0], whatever A is doing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= '0;
            q_neg <= 1'b0;
        end else begin
            case (q_op)
                Q_HOLD: begin
                    q_reg <= q_reg;
                    q_neg <= q_neg;
                end
                Q_LOAD: begin
                    q_reg <= multiplier;
                    q_neg <= 1'b0;
                end
                Q_SHR: begin
                    q_reg <= {a_reg[0], q_reg[WIDTH-1:1]};
                    q_neg <= q_reg[0];
                end
                Q_CLEAR: begin
                    q_reg <= '0;
                    q_neg <= 1'b0;
                end
            endcase
        end
    end

    assign qReg = q_reg;
    assign qNeg = q_neg;
    assign aReg = a_reg[WIDTH-1:0];

    // productValid is a level qualifier with no ready/back-pressure: whenever it is
    // high, product holds the finished result and the consumer may sample it.
`ifdef BOOTH_PRODUCT_REG_EN
    logic                 finished_d;
    logic [2*WIDTH-1:0]   product_reg;
    logic                 valid_reg;
    logic                 finish_rise;

    assign finish_rise = finished && !finished_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            finished_d  <= 1'b0;
            product_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            finished_d <= finished;
            if (finish_rise) begin
                product_reg <= {a_reg[WIDTH-1:0], q_reg};
                valid_reg   <= 1'b1;
            end else if (q_op == Q_LOAD) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign product      = product_reg;
    assign productValid = valid_reg;
`else
    assign product      = {a_reg[WIDTH-1:0], q_reg};
    assign productValid = finished;
`endif

endmodule
